// File: rtl/parallel_in_serial_out_piso_tx.sv
// ---------------------------------------------------------------------------
// parallel_in_serial_out_piso_tx
//   Parallel-in, serial-out transmit shifter with a valid/ready load handshake.
//   An accepted word is shifted out one bit per enabled clock. Serial_Valid_Out
//   frames the bits, and Last_Bit_Out marks the final bit. A new word may be
//   accepted during the last-bit cycle, so consecutive words go out with no gap.
//
// Parameters
//   DATA_WIDTH : word width in bits (>= 2)
//   MSB_FIRST  : 1 sends bit DATA_WIDTH-1 first, 0 sends bit 0 first
//
// Ports
//   Clk_In           in   clock, rising edge
//   Reset_In         in   synchronous active-high reset
//   Enable_In        in   clock enable; low freezes all state
//   Data_Valid_In    in   word present on Parallel_Data_In
//   Parallel_Data_In in   word to transmit
//   Data_Ready_Out   out  a word can be accepted this cycle
//   Serial_Data_Out  out  current serial bit
//   Serial_Valid_Out out  Serial_Data_Out carries a frame bit
//   Last_Bit_Out     out  current bit is the final bit of the word
// ---------------------------------------------------------------------------
module parallel_in_serial_out_piso_tx #(
  parameter int DATA_WIDTH = 8,
  parameter bit MSB_FIRST  = 1'b1
) (
  input  logic                  Clk_In,
  input  logic                  Reset_In,
  input  logic                  Enable_In,
  input  logic                  Data_Valid_In,
  input  logic [DATA_WIDTH-1:0] Parallel_Data_In,
  output logic                  Data_Ready_Out,
  output logic                  Serial_Data_Out,
  output logic                  Serial_Valid_Out,
  output logic                  Last_Bit_Out
);

  localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CW-1:0] LAST_COUNT = CW'(DATA_WIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic [DATA_WIDTH-1:0] r_shift;
  logic [DATA_WIDTH-1:0] w_shift_next;
  logic [CW-1:0]         r_count;
  logic [CW-1:0]         w_count_next;

  logic w_last_count;
  logic w_ready;
  logic w_accept;
  logic w_out_bit;

  assign w_last_count = (r_count == LAST_COUNT);
  // Enable_In is folded into ready, so an accept can only occur on an enabled edge.
  assign w_ready      = Enable_In & ((r_state == IDLE) | ((r_state == SHIFT) & w_last_count));
  assign w_accept     = w_ready & Data_Valid_In;
  assign w_out_bit    = MSB_FIRST ? r_shift[DATA_WIDTH-1] : r_shift[0];

  // State register
  always_ff @(posedge Clk_In) begin
    if (Reset_In) begin
      r_state <= IDLE;
      r_shift <= '0;
      r_count <= '0;
    end else begin
      r_state <= w_state_next;
      r_shift <= w_shift_next;
      r_count <= w_count_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    w_shift_next = r_shift;
    w_count_next = r_count;
    if (Enable_In) begin
      if (w_accept) begin
        w_state_next = SHIFT;
        w_shift_next = Parallel_Data_In;
        w_count_next = '0;
      end else if (r_state == SHIFT) begin
        if (!w_last_count) begin
          // Move the next bit toward the output end, zero-filling behind it.
          if (MSB_FIRST)
            w_shift_next = {r_shift[DATA_WIDTH-2:0], 1'b0};
          else
            w_shift_next = {1'b0, r_shift[DATA_WIDTH-1:1]};
          w_count_next = r_count + 1'b1;
        end else begin
          w_state_next = IDLE;
          w_shift_next = '0;
          w_count_next = '0;
        end
      end
    end
  end

  // Output logic. While disabled, the data bit stays visible but is not
  // qualified, so it is re-presented once Enable_In returns.
  always_comb begin
    Data_Ready_Out   = w_ready;
    Serial_Data_Out  = 1'b0;
    Serial_Valid_Out = 1'b0;
    Last_Bit_Out     = 1'b0;
    if (r_state == SHIFT) begin
      Serial_Data_Out  = w_out_bit;
      Serial_Valid_Out = Enable_In;
      Last_Bit_Out     = Enable_In & w_last_count;
    end
  end

endmodule

// File: tb/tb_parallel_in_serial_out_piso_tx.sv
// ---------------------------------------------------------------------------
// tb_parallel_in_serial_out_piso_tx
//   Directed bench for the PISO transmitter. It uses an MSB-first instance and
//   an LSB-first instance that share all inputs. Cycle n is the interval after
//   rising edge n-1. Outputs are sampled 1 time unit after each rising edge.
// ---------------------------------------------------------------------------
module tb_parallel_in_serial_out_piso_tx;

  logic       clk;
  logic       rst;
  logic       en;
  logic       valid;
  logic [7:0] data;

  logic m_rdy, m_sd, m_sv, m_lb;
  logic l_rdy, l_sd, l_sv, l_lb;

  int checks = 0;
  int errors = 0;

  logic [7:0]  pat8;
  logic [15:0] pat16;
  logic [4:0]  resume;

  parallel_in_serial_out_piso_tx #(.DATA_WIDTH(8), .MSB_FIRST(1'b1)) u_msb (
    .Clk_In(clk), .Reset_In(rst), .Enable_In(en), .Data_Valid_In(valid),
    .Parallel_Data_In(data), .Data_Ready_Out(m_rdy), .Serial_Data_Out(m_sd),
    .Serial_Valid_Out(m_sv), .Last_Bit_Out(m_lb)
  );

  parallel_in_serial_out_piso_tx #(.DATA_WIDTH(8), .MSB_FIRST(1'b0)) u_lsb (
    .Clk_In(clk), .Reset_In(rst), .Enable_In(en), .Data_Valid_In(valid),
    .Parallel_Data_In(data), .Data_Ready_Out(l_rdy), .Serial_Data_Out(l_sd),
    .Serial_Valid_Out(l_sv), .Last_Bit_Out(l_lb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_m(input string tag, input logic sd, input logic sv,
                       input logic lb, input logic rdy);
    chk({tag, ".sd"},  m_sd,  sd);
    chk({tag, ".sv"},  m_sv,  sv);
    chk({tag, ".lb"},  m_lb,  lb);
    chk({tag, ".rdy"}, m_rdy, rdy);
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; valid = 1'b0; data = '0;
    tick(); tick();
    rst = 1'b0;
    chk_m("reset", 1'b0, 1'b0, 1'b0, 1'b1);
    chk("reset.lsb_sv", l_sv, 1'b0);
    chk("reset.lsb_rdy", l_rdy, 1'b1);

    // MSB-first 0xB4; the LSB instance sends the same word as 0,0,1,0,1,1,0,1
    pat8 = 8'hB4;
    valid = 1'b1; data = 8'hB4;
    tick();
    valid = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      chk_m($sformatf("msb_b4.c%0d", i), pat8[8-i], 1'b1, (i == 8), (i == 8));
      chk($sformatf("lsb_b4.c%0d.sd", i), l_sd, pat8[i-1]);
      tick();
    end
    chk_m("msb_b4.c9", 1'b0, 1'b0, 1'b0, 1'b1);

    // LSB-first 0x01
    valid = 1'b1; data = 8'h01;
    tick();
    valid = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      chk($sformatf("lsb_01.c%0d.sd", i), l_sd, (i == 1));
      chk($sformatf("lsb_01.c%0d.sv", i), l_sv, 1'b1);
      chk($sformatf("lsb_01.c%0d.lb", i), l_lb, (i == 8));
      tick();
    end
    chk("lsb_01.c9.sv", l_sv, 1'b0);

    // Back-to-back 0xB4 then 0x0F; valid held through the busy cycles
    pat16 = 16'hB40F;
    valid = 1'b1; data = 8'hB4;
    tick();
    data = 8'h0F;
    for (int i = 1; i <= 16; i++) begin
      chk_m($sformatf("b2b.c%0d", i), pat16[16-i], 1'b1,
            (i == 8 || i == 16), (i == 8 || i == 16));
      tick();
      if (i == 8) valid = 1'b0;
    end
    chk_m("b2b.c17", 1'b0, 1'b0, 1'b0, 1'b1);

    // Enable stall after bit 3 of 0xB4
    valid = 1'b1; data = 8'hB4;
    tick();
    valid = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      chk_m($sformatf("stall.c%0d", i), pat8[8-i], 1'b1, 1'b0, 1'b0);
      tick();
    end
    en = 1'b0;
    #1;
    for (int s = 0; s < 3; s++) begin
      chk_m($sformatf("stall.hold%0d", s), 1'b1, 1'b0, 1'b0, 1'b0);
      tick();
    end
    en = 1'b1;
    #1;
    resume = 5'b10100;
    for (int j = 0; j < 5; j++) begin
      chk_m($sformatf("stall.res%0d", j), resume[4-j], 1'b1, (j == 4), (j == 4));
      tick();
    end
    chk_m("stall.end", 1'b0, 1'b0, 1'b0, 1'b1);

    // Reset after bit 4 of 0xFF, then 0x80
    valid = 1'b1; data = 8'hFF;
    tick();
    valid = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      chk_m($sformatf("rst_ff.c%0d", i), 1'b1, 1'b1, 1'b0, 1'b0);
      if (i == 4) rst = 1'b1;
      tick();
    end
    rst = 1'b0;
    chk_m("rst_ff.after", 1'b0, 1'b0, 1'b0, 1'b1);
    valid = 1'b1; data = 8'h80;
    tick();
    valid = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      chk_m($sformatf("post_rst_80.c%0d", i), (i == 1), 1'b1, (i == 8), (i == 8));
      tick();
    end
    chk_m("post_rst_80.c9", 1'b0, 1'b0, 1'b0, 1'b1);

    // 0x55 presented for one cycle while busy in cycle 3 is ignored
    valid = 1'b1; data = 8'hB4;
    tick();
    valid = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      if (i == 3) begin valid = 1'b1; data = 8'h55; end
      chk_m($sformatf("busy.c%0d", i), pat8[8-i], 1'b1, (i == 8), (i == 8));
      tick();
      if (i == 3) valid = 1'b0;
    end
    chk_m("busy.c9", 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    chk_m("busy.c10", 1'b0, 1'b0, 1'b0, 1'b1);

    // Ready follows Enable_In in IDLE
    en = 1'b0;
    #1;
    chk("idle_dis.rdy", m_rdy, 1'b0);
    en = 1'b1;
    #1;
    chk("idle_en.rdy", m_rdy, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/parallel_in_serial_out_piso_tx.md
# parallel_in_serial_out_piso_tx

Parallel-in, serial-out (PISO) transmit shifter with a valid/ready load handshake. It accepts a parallel word and shifts it out one bit per enabled clock, framed by a valid strobe and a last-bit marker. It is the transmit end for the team's serial-in/parallel-out receive shift registers, and it turns the parallel data held in the PIPO registers into a serial bitstream. It supports back-to-back words with no idle gap.

## Interface
Parameters:
- DATA_WIDTH, 8, word width in bits; legal values are 2 or more.
- MSB_FIRST, 1, bit order: 1 sends bit DATA_WIDTH-1 first, 0 sends bit 0 first.

Ports:
- Clk_In  input  1  the only clock; all state changes on its rising edge.
- Reset_In  input  1  synchronous, active-high reset.
- Enable_In  input  1  clock enable; when low, all state is frozen.
- Data_Valid_In  input  1  a word is presented on Parallel_Data_In.
- Parallel_Data_In  input  DATA_WIDTH  word to transmit.
- Data_Ready_Out  output  1  the block can accept a word this cycle.
- Serial_Data_Out  output  1  current serial bit.
- Serial_Valid_Out  output  1  Serial_Data_Out carries a frame bit this cycle.
- Last_Bit_Out  output  1  the current bit is the final bit of the word.

## Operation
- **State machine:** two states, IDLE and SHIFT. Internal state is a DATA_WIDTH shift register plus a bit counter of width $clog2(DATA_WIDTH).
- **Accept:** a word is accepted when Enable_In, Data_Valid_In and Data_Ready_Out are all high at a rising edge. On accept:
  - shift register <= Parallel_Data_In;
  - counter <= 0;
  - state <= SHIFT.
- **Data_Ready_Out** (combinational) = Enable_In & ((state == IDLE) | (state == SHIFT & counter == DATA_WIDTH-1)).
- **SHIFT outputs:**
  - Serial_Data_Out = shift register bit DATA_WIDTH-1 when MSB_FIRST = 1, else bit 0.
  - Serial_Valid_Out = Enable_In.
  - Last_Bit_Out = Enable_In & (counter == DATA_WIDTH-1).
- **SHIFT, each enabled edge, counter < DATA_WIDTH-1:** shift by one toward the output end, zero-filling the vacated bit; counter <= counter+1.
- **SHIFT, enabled edge, counter == DATA_WIDTH-1:**
  - if an accept happens on the same edge, load the new word, counter <= 0, stay in SHIFT (no gap);
  - otherwise state <= IDLE, shift register <= 0, counter <= 0.
- **IDLE outputs:** Serial_Data_Out = 0, Serial_Valid_Out = 0, Last_Bit_Out = 0.
- **Enable_In low:**
  - state, counter and shift register hold;
  - Serial_Valid_Out, Last_Bit_Out and Data_Ready_Out are forced to 0;
  - Serial_Data_Out holds the current bit;
  - the held bit is re-presented when Enable_In returns.
- **Data_Valid_In ignored:** while Data_Ready_Out = 0, the word is not accepted and it is not queued. The source must hold Data_Valid_In until it sees Data_Ready_Out.
- **Reset_In high at an edge:**
  - state <= IDLE, shift register <= 0, counter <= 0;
  - takes priority over accept and over Enable_In;
  - any frame in progress is aborted and its word discarded.

## Timing
- **Reset values** (after reset edge): Serial_Data_Out 0, Serial_Valid_Out 0, Last_Bit_Out 0. Data_Ready_Out follows Enable_In.
- **Latency:** accept at edge k puts the first bit on Serial_Data_Out in cycle k+1, i.e. combinationally after edge k.
- **Frame length:** one word occupies exactly DATA_WIDTH enabled cycles. Disabled cycles stretch the frame without dropping or duplicating a counted bit.
- **Last_Bit_Out:** exactly one enabled cycle per word, coincident with the final bit.
- **Throughput:** one bit per enabled cycle, sustained, when the next word is accepted during the last-bit cycle.
- **Combinational paths:** no path from Data_Valid_In or Parallel_Data_In to any output. Enable_In reaches the outputs combinationally.

## Test plan
- **MSB-first single word:** DATA_WIDTH=8, MSB_FIRST=1, Enable_In=1, load 0xB4 at edge 0.
  - Cycles 1..8 show Serial_Data_Out 1,0,1,1,0,1,0,0 with Serial_Valid_Out=1.
  - Last_Bit_Out=1 only in cycle 8.
  - Cycle 9: IDLE, Data_Ready_Out=1, Serial_Valid_Out=0.
- **LSB-first single word:** MSB_FIRST=0, load 0x01.
  - Serial_Data_Out is 1 in cycle 1, then 0 for cycles 2..8.
  - Last_Bit_Out in cycle 8.
- **Back-to-back:** load 0xB4; hold Data_Valid_In with 0x0F.
  - The second word is accepted at the edge ending cycle 8.
  - 16 contiguous valid bits: 1,0,1,1,0,1,0,0,0,0,0,0,1,1,1,1.
  - Data_Ready_Out is low in cycles 1..7 and high in cycle 8.
- **Enable stall:** load 0xB4; drop Enable_In for 3 cycles after bit 3.
  - Serial_Valid_Out=0 and Serial_Data_Out holds 1 during the stall.
  - On resume, bits continue 1,0,1,0,0.
  - The frame spans 11 cycles; Last_Bit_Out fires once.
- **Reset mid-frame:** load 0xFF; assert Reset_In at the edge after bit 4.
  - Next cycle: Serial_Valid_Out=0, Serial_Data_Out=0, Data_Ready_Out=1.
  - A following load of 0x80 transmits 1 then seven 0s.
- **Valid while busy:** present 0x55 with Data_Valid_In=1 for one cycle during cycle 3 of an 0xB4 frame.
  - It is not accepted; the 0xB4 bitstream is unchanged.
  - The block returns to IDLE after cycle 8.
